// File: rtl/branch_predict_resolve_unit_if.sv
// Branch predict/resolve bus.
// Groups the fetch-stage prediction request and response, the resolve-stage
// branch information, and the resolve results and statistics.
//   master : the pipeline side. It drives pred_pc and the resolve inputs,
//            and receives the prediction, the resolve results and the counts.
//   slave  : branch_predict_resolve_unit.
interface branch_predict_resolve_unit_if #(
    parameter int XLEN      = 32,
    parameter int STAT_BITS = 32
);
    logic [XLEN-1:0]      pred_pc;
    logic                 pred_taken;
    logic                 res_valid;
    logic [XLEN-1:0]      res_pc;
    logic                 branch_signal;
    logic [2:0]           funct3;
    logic                 zf;
    logic                 cf;
    logic                 sf;
    logic                 vf;
    logic                 res_pred_taken;
    logic                 pc_src;
    logic                 mispredict;
    logic [STAT_BITS-1:0] branch_count;
    logic [STAT_BITS-1:0] mispredict_count;

    modport master (
        output pred_pc, res_valid, res_pc, branch_signal, funct3,
               zf, cf, sf, vf, res_pred_taken,
        input  pred_taken, pc_src, mispredict, branch_count, mispredict_count
    );

    modport slave (
        input  pred_pc, res_valid, res_pc, branch_signal, funct3,
               zf, cf, sf, vf, res_pred_taken,
        output pred_taken, pc_src, mispredict, branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_predict_resolve_unit.sv
// Branch resolve and prediction unit for the RV32 core.
// It resolves conditional branches from the ALU flags (rs1 - rs2) and funct3.
// A table of saturating counters, indexed by PC[IDX_BITS+1:2], supplies the
// fetch-stage taken prediction. The unit flags mispredictions against the
// prediction that was carried down the pipe with the branch, and it keeps
// wrap-around counts of resolved branches and mispredicts.
// Ports:
//   clk : rising-edge clock.
//   rst : synchronous active-high reset. It loads every counter with the
//         weakly not-taken value and clears the statistics.
//   bus : slave side of branch_predict_resolve_unit_if.
//         pred_taken, pc_src and mispredict are combinational.
//         branch_count and mispredict_count are registered.
module branch_predict_resolve_unit #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CTR_BITS    = 2,
    parameter int STAT_BITS   = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    branch_predict_resolve_unit_if.slave bus
);
    localparam int IDX_BITS = $clog2(BHT_ENTRIES);
    localparam logic [CTR_BITS-1:0]  CTR_ONE  = CTR_BITS'(1);
    localparam logic [CTR_BITS-1:0]  CTR_ZERO = CTR_BITS'(0);
    localparam logic [CTR_BITS-1:0]  CTR_MAX  = {CTR_BITS{1'b1}};
    // The weakly not-taken value sits just below the taken threshold.
    localparam logic [CTR_BITS-1:0]  CTR_RST  = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [STAT_BITS-1:0] STAT_ONE = STAT_BITS'(1);

    // Branch condition from the flags of rs1 - rs2. Non-branch codes give 0.
    function automatic logic branch_cond(input logic [2:0] f3, input logic z,
                                         input logic c, input logic s, input logic v);
        case (f3)
            3'b000:  branch_cond = z;          // BEQ
            3'b001:  branch_cond = ~z;         // BNE
            3'b100:  branch_cond = (s != v);   // BLT
            3'b101:  branch_cond = (s == v);   // BGE
            3'b110:  branch_cond = ~c;         // BLTU (carry means no borrow)
            3'b111:  branch_cond = c;          // BGEU
            default: branch_cond = 1'b0;
        endcase
    endfunction

    // True for the six conditional-branch encodings.
    function automatic logic legal_funct3(input logic [2:0] f3);
        legal_funct3 = (f3 != 3'b010) && (f3 != 3'b011);
    endfunction

    logic [CTR_BITS-1:0]  bht_r [BHT_ENTRIES];
    logic [IDX_BITS-1:0]  ridx_s;
    logic [IDX_BITS-1:0]  pidx_s;
    logic                 cond_s;
    logic                 resolving_s;
    logic                 mispredict_s;
    logic [CTR_BITS-1:0]  ctr_cur_s;
    logic [CTR_BITS-1:0]  ctr_next_s;
    logic [STAT_BITS-1:0] branch_count_r;
    logic [STAT_BITS-1:0] mispredict_count_r;
    logic                 unused_pc_bits_s;

    // Upper PC bits are dropped, so distant branches may share an entry.
    assign ridx_s = bus.res_pc[IDX_BITS+1:2];
    assign pidx_s = bus.pred_pc[IDX_BITS+1:2];
    assign unused_pc_bits_s = ^{bus.res_pc[XLEN-1:IDX_BITS+2], bus.res_pc[1:0],
                                bus.pred_pc[XLEN-1:IDX_BITS+2], bus.pred_pc[1:0]};

    // Resolve-stage decode: the condition, whether a real branch resolves, and misprediction.
    always_comb begin
        cond_s       = branch_cond(bus.funct3, bus.zf, bus.cf, bus.sf, bus.vf);
        resolving_s  = bus.res_valid & bus.branch_signal & legal_funct3(bus.funct3);
        mispredict_s = resolving_s & (cond_s != bus.res_pred_taken);
    end

    // Saturating next value for the counter of the resolving branch.
    always_comb begin
        ctr_cur_s  = bht_r[ridx_s];
        ctr_next_s = ctr_cur_s;
        if (cond_s) begin
            if (ctr_cur_s != CTR_MAX) begin
                ctr_next_s = ctr_cur_s + CTR_ONE;
            end else begin
                ctr_next_s = ctr_cur_s;
            end
        end else begin
            if (ctr_cur_s != CTR_ZERO) begin
                ctr_next_s = ctr_cur_s - CTR_ONE;
            end else begin
                ctr_next_s = ctr_cur_s;
            end
        end
    end

    // Counter table. The whole table resets in one cycle and there is no read bypass.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_r[i] <= CTR_RST;
            end
        end else if (resolving_s) begin
            bht_r[ridx_s] <= ctr_next_s;
        end else begin
            bht_r[ridx_s] <= bht_r[ridx_s];
        end
    end

    // Statistics counters. Both wrap silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_count_r     <= {STAT_BITS{1'b0}};
            mispredict_count_r <= {STAT_BITS{1'b0}};
        end else begin
            if (resolving_s) begin
                branch_count_r <= branch_count_r + STAT_ONE;
            end else begin
                branch_count_r <= branch_count_r;
            end
            if (mispredict_s) begin
                mispredict_count_r <= mispredict_count_r + STAT_ONE;
            end else begin
                mispredict_count_r <= mispredict_count_r;
            end
        end
    end

    assign bus.pred_taken       = bht_r[pidx_s][CTR_BITS-1];
    assign bus.pc_src           = cond_s & bus.res_valid & bus.branch_signal;
    assign bus.mispredict       = mispredict_s;
    assign bus.branch_count     = branch_count_r;
    assign bus.mispredict_count = mispredict_count_r;
endmodule
